// File: rtl/led_pio_sequencer_if.sv
// Avalon-MM bundle for the LED pattern sequencer:
// CPU-facing slave port plus the master port toward the LED PIO.
interface led_pio_sequencer_if;
    logic [3:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    modport slave (
        input  s_address,
        input  s_chipselect,
        input  s_write_n,
        input  s_writedata,
        output s_readdata,
        output m_address,
        output m_write,
        output m_writedata,
        input  m_waitrequest
    );

    modport master (
        output s_address,
        output s_chipselect,
        output s_write_n,
        output s_writedata,
        input  s_readdata,
        input  m_address,
        input  m_write,
        input  m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/led_pio_sequencer.sv
// Autonomous 8-entry LED pattern sequencer: CPU loads patterns and
// a step period, the master port streams them to the LED PIO.
module led_pio_sequencer #(
    parameter int         PERIOD_W = 24,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input logic               clk,
    input logic               reset_n,
    led_pio_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t              state;
    logic                en;
    logic                oneshot;
    logic [2:0]          last;
    logic [2:0]          idx;
    logic                done;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [15:0]         pat [8];
    logic                mw;
    logic [15:0]         md;

    logic        wr;
    logic        wr_ctrl;
    logic        wr_per;
    logic        wr_stat;
    logic        wr_pat;
    logic [31:0] wd;
    logic        accept;
    logic        start;
    logic        busy;
    logic [31:0] rd;
    logic        unused_wd;

    assign wd        = bus.s_writedata;
    assign wr        = bus.s_chipselect && !bus.s_write_n;
    assign wr_ctrl   = wr && (bus.s_address == 4'd0);
    assign wr_per    = wr && (bus.s_address == 4'd1);
    assign wr_stat   = wr && (bus.s_address == 4'd2);
    assign wr_pat    = wr && bus.s_address[3];
    assign accept    = mw && !bus.m_waitrequest;
    assign start     = wr_ctrl && wd[0] && !en;
    assign busy      = (state != IDLE);
    assign unused_wd = ^wd[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            en      <= 1'b0;
            oneshot <= 1'b0;
            last    <= '0;
            idx     <= '0;
            done    <= 1'b0;
            period  <= '0;
            cnt     <= '0;
            mw      <= 1'b0;
            md      <= '0;
            for (int i = 0; i < 8; i++) pat[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                en      <= wd[0];
                oneshot <= wd[1];
                last    <= wd[6:4];
            end
            if (wr_per) period <= wd[PERIOD_W-1:0];
            if (wr_stat && wd[8]) done <= 1'b0;
            if (wr_pat) pat[bus.s_address[2:0]] <= wd[15:0];

            // FSM updates come last so a completion beats a same-cycle clear
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        md    <= pat[0];
                        mw    <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        mw <= 1'b0;
                        if (!en) begin
                            state <= IDLE;
                        end else if (oneshot && idx >= last) begin
                            done  <= 1'b1;
                            en    <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx   <= (idx >= last) ? 3'd0 : idx + 3'd1;
                            cnt   <= period;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        md    <= pat[idx];
                        mw    <= 1'b1;
                        state <= WRITE;
                    end else begin
                        cnt <= cnt - PERIOD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        unique case (1'b1)
            bus.s_address == 4'd0: rd = {25'd0, last, 2'b00, oneshot, en};
            bus.s_address == 4'd1: rd = {{(32-PERIOD_W){1'b0}}, period};
            bus.s_address == 4'd2: rd = {23'd0, done, 1'b0, idx, 3'b000, busy};
            bus.s_address[3]:      rd = {16'd0, pat[bus.s_address[2:0]]};
            default:               rd = '0;
        endcase
    end

    assign bus.s_readdata  = rd;
    assign bus.m_address   = PIO_ADDR;
    assign bus.m_write     = mw;
    assign bus.m_writedata = {16'd0, md};

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: randomized pattern runs
// compared against an arithmetic model of the step schedule.
module tb_led_pio_sequencer;

    logic clk;
    logic reset_n;
    int   cyc;
    int   tests;
    int   fails;
    int   wcyc;

    led_pio_sequencer_if bus ();

    led_pio_sequencer #(.PERIOD_W(24), .PIO_ADDR(2'd0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int          acc_cyc [$];
    logic [31:0] acc_dat [$];

    always @(negedge clk) begin
        if (bus.m_write && !bus.m_waitrequest) begin
            acc_cyc.push_back(cyc);
            acc_dat.push_back(bus.m_writedata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wcyc = cyc;
        bus.s_address    = a;
        bus.s_writedata  = d;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.s_address = a;
        #1;
        d = bus.s_readdata;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k;
        k = 0;
        while (acc_dat.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("acc_timeout", 32'(acc_dat.size() >= n), 32'd1);
    endtask

    task automatic clr_q();
        acc_cyc.delete();
        acc_dat.delete();
    endtask

    logic [31:0] r;
    logic [15:0] p [8];
    int          last_v;
    int          per_v;
    int          n;
    int          t0;

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        reset_n          = 1'b0;
        bus.s_address    = '0;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
        bus.s_writedata  = '0;
        bus.m_waitrequest = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);

        rd(4'd0, r); chk("rst_ctrl", r, 32'h0);
        rd(4'd1, r); chk("rst_period", r, 32'h0);
        rd(4'd2, r); chk("rst_status", r, 32'h0);
        chk("rst_mwrite", 32'(bus.m_write), 32'h0);
        chk("rst_mdata", bus.m_writedata, 32'h0);
        chk("rst_maddr", 32'(bus.m_address), 32'h0);

        // Free-running sequences: directed first, then randomized
        for (int it = 0; it < 3; it++) begin
            last_v = (it == 0) ? 3 : int'($urandom_range(1, 7));
            per_v  = (it == 0) ? 5 : int'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++)
                p[i] = (it == 0) ? 16'(1 << i) : 16'($urandom);
            for (int i = 0; i < 8; i++) wr(4'(8 + i), {16'hDEAD, p[i]});
            wr(4'd1, 32'(per_v));
            clr_q();
            wr(4'd0, 32'(last_v << 4) | 32'h1);
            t0 = wcyc;
            n  = 2 * (last_v + 1) + 1;
            wait_acc(n, n * (per_v + 2) + 20);
            for (int j = 0; j < n; j++) begin
                if (j < acc_dat.size()) begin
                    chk($sformatf("run%0d_dat%0d", it, j), acc_dat[j],
                        {16'd0, p[j % (last_v + 1)]});
                    chk($sformatf("run%0d_cyc%0d", it, j), 32'(acc_cyc[j]),
                        32'(t0 + 1 + j * (per_v + 2)));
                end
            end
            chk("run_maddr", 32'(bus.m_address), 32'h0);
            wr(4'd0, 32'h0);
            step(20);
            rd(4'd2, r);
            chk("run_stop_busy", 32'(r[0]), 32'h0);
        end

        // One-shot, LAST=2, PERIOD=0
        for (int i = 0; i < 3; i++) p[i] = 16'($urandom);
        for (int i = 0; i < 3; i++) wr(4'(8 + i), {16'd0, p[i]});
        wr(4'd1, 32'h0);
        clr_q();
        wr(4'd0, 32'h23);
        t0 = wcyc;
        wait_acc(3, 30);
        step(10);
        chk("os_count", 32'(acc_dat.size()), 32'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < acc_dat.size()) begin
                chk($sformatf("os_dat%0d", j), acc_dat[j], {16'd0, p[j]});
                chk($sformatf("os_cyc%0d", j), 32'(acc_cyc[j]),
                    32'(t0 + 1 + 2 * j));
            end
        end
        rd(4'd2, r); chk("os_status", r, 32'h120);
        rd(4'd0, r); chk("os_ctrl", r, 32'h22);
        wr(4'd2, 32'h100);
        rd(4'd2, r); chk("os_done_clr", r, 32'h020);

        // Stall for 4 cycles, EN cleared mid-stall
        p[0] = 16'($urandom);
        wr(4'd8, {16'd0, p[0]});
        wr(4'd1, 32'd2);
        bus.m_waitrequest = 1'b1;
        clr_q();
        wr(4'd0, 32'h11);
        @(negedge clk);
        chk("st_mw0", 32'(bus.m_write), 32'h1);
        chk("st_md0", bus.m_writedata, {16'd0, p[0]});
        wr(4'd0, 32'h10);
        @(negedge clk);
        chk("st_mw1", 32'(bus.m_write), 32'h1);
        chk("st_md1", bus.m_writedata, {16'd0, p[0]});
        for (int i = 0; i < 2; i++) begin
            step(1);
            @(negedge clk);
            chk($sformatf("st_mw%0d", i + 2), 32'(bus.m_write), 32'h1);
            chk($sformatf("st_md%0d", i + 2), bus.m_writedata, {16'd0, p[0]});
        end
        step(1);
        bus.m_waitrequest = 1'b0;
        step(20);
        chk("st_count", 32'(acc_dat.size()), 32'd1);
        if (acc_dat.size() > 0) chk("st_dat", acc_dat[0], {16'd0, p[0]});
        rd(4'd2, r); chk("st_busy", 32'(r[0]), 32'h0);

        // LAST shortened mid-run, PAT[0] rewritten during WAIT
        for (int i = 0; i < 8; i++) p[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) wr(4'(8 + i), {16'd0, p[i]});
        wr(4'd1, 32'd8);
        clr_q();
        wr(4'd0, 32'h71);
        wait_acc(5, 80);
        rd(4'd2, r); chk("ls_status_idx5", r, 32'h051);
        wr(4'd0, 32'h31);
        wait_acc(6, 30);
        rd(4'd2, r); chk("ls_wrap_idx0", r, 32'h001);
        wr(4'd8, 32'h0000BEEF);
        wait_acc(7, 30);
        if (acc_dat.size() >= 7) begin
            chk("ls_dat4", acc_dat[4], {16'd0, p[4]});
            chk("ls_dat5", acc_dat[5], {16'd0, p[5]});
            chk("ls_dat6", acc_dat[6], 32'h0000BEEF);
        end
        wr(4'd0, 32'h0);
        step(20);

        // Asynchronous reset while a transfer is stalled
        bus.m_waitrequest = 1'b1;
        wr(4'd0, 32'h01);
        #2;
        chk("ar_mw_before", 32'(bus.m_write), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("ar_mw_async", 32'(bus.m_write), 32'h0);
        chk("ar_md_async", bus.m_writedata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.m_waitrequest = 1'b0;
        step(1);
        for (int a = 0; a < 16; a++) begin
            if (a < 3 || a >= 8) begin
                rd(4'(a), r);
                chk($sformatf("ar_reg%0d", a), r, 32'h0);
            end
        end

        // DONE set and write-1-clear in the same cycle
        wr(4'd8, 32'h0000A5A5);
        bus.m_waitrequest = 1'b1;
        wr(4'd0, 32'h03);
        step(1);
        bus.m_waitrequest = 1'b0;
        wr(4'd2, 32'h100);
        rd(4'd2, r); chk("dc_done_wins", r, 32'h100);
        wr(4'd2, 32'h100);
        rd(4'd2, r); chk("dc_done_clr", r, 32'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_pio_sequencer.md
# led_pio_sequencer

Autonomous pattern sequencer for the 16-bit LED PIO output register. It holds an 8-entry pattern table and a step period, both loaded by the CPU over an Avalon-MM slave port. An Avalon-MM master port writes the patterns in order to the LED PIO data register (offset 0), so the CPU does not have to service blink and chase patterns. It sits between the Qsys interconnect (slave side) and the LED PIO s1 port (master side).

## Interface
- PERIOD_W, 24, width of the step-period counter and PERIOD register
- PIO_ADDR, 2'd0, word address driven on m_address (LED PIO data register)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- s_address  in  4  slave word address
- s_chipselect  in  1  slave select
- s_write_n  in  1  slave write strobe, active-low
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data, combinational from s_address, zero wait states
- m_address  out  2  master word address, constant PIO_ADDR
- m_write  out  1  master write request
- m_writedata  out  32  {16'b0, pattern}
- m_waitrequest  in  1  master stall from interconnect

## Operation
- Register map (word addresses):
  - 0 CTRL, R/W: bit0 EN; bit1 ONESHOT; bits6:4 LAST (index of the final entry).
  - 1 PERIOD, R/W: bits PERIOD_W-1:0.
  - 2 STATUS: bit0 BUSY (R), bits6:4 IDX (R), bit8 DONE (R, write 1 to clear).
  - 8..15 PAT[0..7], R/W: bits15:0.
  - Unused bits and unmapped addresses read 0. Writes to unmapped addresses are ignored.
- Slave writes take effect when s_chipselect && !s_write_n.
- States: IDLE, WRITE, WAIT.
- IDLE:
  - A write that takes EN from 0 to 1 sets IDX=0, latches PAT[0] into m_writedata, and enters WRITE.
- WRITE:
  - m_write=1, with m_address and m_writedata held stable.
  - The transfer is accepted on a cycle with m_write && !m_waitrequest.
  - On acceptance, if EN was cleared during the transfer: go to IDLE.
  - Else, if ONESHOT && IDX>=LAST: set DONE, clear EN, go to IDLE.
  - Else: IDX <= (IDX>=LAST) ? 0 : IDX+1, load the counter with PERIOD, go to WAIT.
- WAIT:
  - The counter decrements every cycle.
  - When the counter is 0, latch PAT[IDX] into m_writedata and go to WRITE.
  - If EN is 0, go to IDLE on the next cycle. No write is issued.
- Writing EN=1 while EN is already 1 does not restart the sequence. ONESHOT and LAST update immediately and apply at the next acceptance.
- Writing a PAT entry while running affects the sequence from its next latch. The in-flight m_writedata never changes.
- BUSY = (state != IDLE).
- DONE: a set and a write-1-to-clear in the same cycle resolve to set.
- Counter arithmetic is unsigned PERIOD_W-bit. PERIOD=0 is legal and means back-to-back steps.

## Timing
- Reset values: all registers, the pattern table, IDX, DONE, the counter, m_write and m_writedata are 0. State is IDLE. m_address is PIO_ADDR.
- Reset asserted mid-transfer drops m_write immediately (asynchronous).
- Enable latency: the EN write in cycle T gives m_write=1 in cycle T+1.
- Step spacing: acceptance in cycle A gives the next m_write assertion in cycle A+PERIOD+2.
  - Derivation: enter WAIT at A+1, counter reaches 0 at A+1+PERIOD, WRITE begins the cycle after.
- m_write is never deasserted before acceptance, including when EN is cleared. Avalon rule.
- Slave reads are combinational. The value reflects register state at the start of the cycle.

## Test plan
- Load PAT[0..3]=0x0001,0x0002,0x0004,0x0008, LAST=3, PERIOD=5, write EN=1 with m_waitrequest=0:
  - Master writes 0x1,0x2,0x4,0x8,0x1,… to address 0.
  - Acceptances are 7 cycles apart. The first m_write comes 1 cycle after the EN write.
- ONESHOT=1, LAST=2, PERIOD=0:
  - Exactly 3 writes on consecutive-plus-one cycles.
  - Then DONE=1, EN=0, BUSY=0.
  - Writing STATUS bit8=1 clears DONE.
- Hold m_waitrequest=1 for 4 cycles during a WRITE and clear EN in the middle of the stall:
  - m_write and m_writedata stay stable until acceptance, then IDLE.
  - No further writes are issued.
- Running with LAST=7 and IDX=5, write LAST=3:
  - After the IDX=5 acceptance, IDX wraps to 0.
  - Rewrite PAT[0]=0xBEEF during WAIT: the next write carries 0x0000BEEF.
- Assert reset_n=0 while m_write=1:
  - m_write=0 asynchronously.
  - All readback registers and PAT entries read 0 after release.
- Clear DONE and have a ONESHOT completion in the same cycle: DONE reads 1.
